// File: rtl/riot_io_timer.sv
// RIOT-style I/O and timer block: up to four I/O ports with direction
// registers, an 8-bit interval timer with a selectable prescaler, and one
// edge-detect input on port 0. Reads are registered onto DO/OE.
module riot_io_timer #(
  parameter int NPORTS   = 2,
  parameter int PORT_W   = 8,
  parameter int EDGE_BIT = 7
) (
  input  logic                     phi2,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     we_n,
  input  logic [4:0]               A,
  input  logic [7:0]               DI,
  output logic [7:0]               DO,
  output logic                     OE,
  input  logic [NPORTS*PORT_W-1:0] PI,
  output logic [NPORTS*PORT_W-1:0] PO,
  output logic [NPORTS*PORT_W-1:0] DDR,
  output logic                     irq_n
);

  // Prescale reload value (divisor minus one) for each prescaler select.
  function automatic logic [9:0] div_m1(input logic [1:0] sel);
    case (sel)
      2'd0:    return 10'd0;
      2'd1:    return 10'd7;
      2'd2:    return 10'd63;
      default: return 10'd1023;
    endcase
  endfunction

  logic              wr_en, rd_en;
  logic              port_hit, wr_port, wr_ddr, wr_edge, wr_timer;
  logic              rd_timer, rd_flags;
  logic [1:0]        port_idx;
  logic              rd_hit;
  logic [7:0]        rd_data;
  logic [PORT_W-1:0] ddr_p, po_p, pi_p;

  logic [7:0]        timer_q;
  logic [9:0]        presc_q;
  logic [1:0]        div_q;
  logic              running_q, tflag_q, tie_q;
  logic              eflag_q, eie_q, pol_q;
  logic [2:0]        sync_q;   // [0],[1]: synchroniser, [2]: previous synchronised value
  logic              edge_hit, tick, wrap;

  // Address decode of the current bus cycle.
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    wr_en    = cs & ~we_n;
    rd_en    = cs & we_n;
    port_idx = A[2:1];
    port_hit = (A[4:3] == 2'b00) && (int'(A[2:1]) < NPORTS);
    wr_port  = wr_en & port_hit & ~A[0];
    wr_ddr   = wr_en & port_hit & A[0];
    wr_edge  = wr_en & (A == 5'h08);
    wr_timer = wr_en & (A[4:3] == 2'b10);
    rd_timer = rd_en & (A == 5'h10);
    rd_flags = rd_en & (A == 5'h11);
  end

  // Read data mux: port pins/latches, direction registers, timer and flags.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = 8'h00;
    ddr_p   = '0;
    po_p    = '0;
    pi_p    = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (int'(port_idx) == p) begin
        ddr_p = DDR[p*PORT_W +: PORT_W];
        po_p  = PO[p*PORT_W +: PORT_W];
        pi_p  = PI[p*PORT_W +: PORT_W];
      end
    end
    if (port_hit) begin
      rd_hit  = 1'b1;
      rd_data = A[0] ? 8'(ddr_p) : 8'((ddr_p & po_p) | (~ddr_p & pi_p));
    end else if (A == 5'h10) begin
      rd_hit  = 1'b1;
      rd_data = timer_q;
    end else if (A == 5'h11) begin
      rd_hit  = 1'b1;
      rd_data = {tflag_q, eflag_q, 6'b0};
    end
  end

  // Port output latches and direction registers.
  always_ff @(posedge phi2 or posedge rst) begin
    // NOTE: the port registers are a handful of flops, so they take the reset like any other state.
    if (rst) begin
      PO  <= '0;
      DDR <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (int'(port_idx) == p) begin
          // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
          if (wr_port) PO[p*PORT_W +: PORT_W]  <= DI[PORT_W-1:0];
          if (wr_ddr)  DDR[p*PORT_W +: PORT_W] <= DI[PORT_W-1:0];
        end
      end
    end
  end

  assign tick = running_q && (presc_q == 10'd0);
  assign wrap = tick && (timer_q == 8'h00);

  // Interval timer: load, prescaled countdown, wrap to 0xFF and flag.
  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      timer_q   <= 8'h00;
      presc_q   <= 10'd0;
      div_q     <= 2'd0;
      running_q <= 1'b0;
      tflag_q   <= 1'b0;
      tie_q     <= 1'b0;
    end else if (wr_timer) begin
      timer_q   <= DI;
      presc_q   <= div_m1(A[1:0]);
      div_q     <= A[1:0];
      running_q <= 1'b1;
      tie_q     <= A[2];
      tflag_q   <= 1'b0;
    end else begin
      if (running_q) begin
        if (presc_q == 10'd0) begin
          timer_q <= timer_q - 8'd1;
          if (timer_q == 8'h00) begin
            // After expiry the timer free-runs at /1 until reloaded.
            div_q   <= 2'd0;
            presc_q <= 10'd0;
          end else begin
            presc_q <= div_m1(div_q);
          end
        end else begin
          presc_q <= presc_q - 10'd1;
        end
      end
      if (wrap)          tflag_q <= 1'b1;
      else if (rd_timer) tflag_q <= 1'b0;
    end
  end

  assign edge_hit = pol_q ? (sync_q[1] & ~sync_q[2]) : (~sync_q[1] & sync_q[2]);

  // Edge detector on port 0: synchroniser, control register and flag.
  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      sync_q  <= 3'b000;
      pol_q   <= 1'b0;
      eie_q   <= 1'b0;
      eflag_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], PI[EDGE_BIT]};
      if (wr_edge) begin
        pol_q <= DI[0];
        eie_q <= DI[1];
      end
      if (edge_hit)      eflag_q <= 1'b1;
      else if (rd_flags) eflag_q <= 1'b0;
    end
  end

  // Registered read port: OE pulses for one cycle after each mapped read.
  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      DO <= 8'h00;
      OE <= 1'b0;
    end else if (rd_en && rd_hit) begin
      DO <= rd_data;
      OE <= 1'b1;
    end else begin
      OE <= 1'b0;
    end
  end

  assign irq_n = ~((tflag_q & tie_q) | (eflag_q & eie_q));

endmodule

// File: doc/riot_io_timer.md
RIOT_IO_TIMER -- requirements
Module: riot_io_timer

Parameters
REQ-001 SHALL have parameter NPORTS, default 2, meaning the number of I/O ports (legal range 1..4).
REQ-002 SHALL have parameter PORT_W, default 8, meaning the width of each port in bits (legal range 1..8).
REQ-003 SHALL have parameter EDGE_BIT, default 7, meaning the port-0 bit watched by the edge detector (legal range 0..PORT_W-1).

Interface
REQ-004 SHALL provide phi2, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL provide rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL provide cs, input, 1 bit: chip select, active high.
REQ-007 SHALL provide we_n, input, 1 bit: 0 = write, 1 = read.
REQ-008 SHALL provide A, input, 5 bits: register address.
REQ-009 SHALL provide DI, input, 8 bits: write data.
REQ-010 SHALL provide DO, output, 8 bits: read data.
REQ-011 SHALL provide OE, output, 1 bit: DO is valid.
REQ-012 SHALL provide PI, input, NPORTS*PORT_W bits: port input pins; port p occupies bits [p*PORT_W +: PORT_W].
REQ-013 SHALL provide PO, output, NPORTS*PORT_W bits: port output latches.
REQ-014 SHALL provide DDR, output, NPORTS*PORT_W bits: direction per bit, 1 = output.
REQ-015 SHALL provide irq_n, output, 1 bit: interrupt request, active low.

Function
REQ-016 SHALL accept an access only on a phi2 edge with cs=1; when cs=0 no register changes state.
REQ-017 Register map SHALL be:
- 0x00+2p: port p data.
- 0x01+2p: DDR p, for p < NPORTS.
- 0x08: edge control, write only; DI[0]=polarity (1 = rising), DI[1]=edge interrupt enable.
- 0x10-0x17 write: load timer; A[1:0] selects the prescaler (/1, /8, /64, /1024); A[2] sets the timer interrupt enable.
- 0x10 read: timer value.
- 0x11 read: flags {tflag, eflag, 6'b0}.
REQ-018 Port data read SHALL return (DDR & PO) | (~DDR & PI) per bit, zero-extended to 8 bits; writes SHALL use DI[PORT_W-1:0].
REQ-019 Reads SHALL be registered: DO/OE SHALL update on the edge that samples the read, so OE=1 for exactly one cycle after each mapped read.
REQ-020 Unmapped reads and idle cycles SHALL give OE=0 with DO holding its last value.
REQ-021 Timer load of value V SHALL set timer=V, prescale counter=N-1 (N = selected divisor), running=1 and tflag=0, and restore the selected divisor.
REQ-022 While running, the prescale counter SHALL decrement every cycle; at 0 it SHALL reload N-1 and the timer SHALL decrement.
REQ-023 On a timer decrement from 0x00, the timer SHALL wrap to 0xFF, tflag SHALL become 1, and the divisor SHALL become /1 until the next load.
REQ-024 Reading 0x10 SHALL clear tflag; if tflag is set in the same cycle, set SHALL win.
REQ-025 PI[EDGE_BIT] of port 0 SHALL pass through a 2-flop synchroniser; eflag SHALL set on the selected edge of the synchronised signal.
REQ-026 Reading 0x11 SHALL return the pre-clear flags and then clear eflag only; if eflag is set in the same cycle, set SHALL win.
REQ-027 irq_n SHALL be ~((tflag & tie) | (eflag & eie)), derived from registers only.
REQ-028 A load in the same cycle as a timer decrement SHALL take priority.

Reset
REQ-029 While rst=1, the following SHALL be held at 0: PO, DDR, timer, prescale counter, running, tflag, eflag, tie, eie, polarity, DO, OE, synchroniser flops; irq_n SHALL be 1.
REQ-030 The timer SHALL not count after reset until the first load.
REQ-031 Reset asserted mid-count SHALL abort the count and clear any pending flags immediately.

Verification
REQ-032 Write DDR0=0x0F, write PO0=0xA5, PI port0=0x3C, then read 0x00 -> DO=0x35 with OE=1 for one cycle.
REQ-033 Write 0x15 (/8, tie=1) with DI=0x02, then wait -> tflag sets and irq_n falls 24 cycles after the load edge; timer reads 0xFF then counts down every cycle.
REQ-034 After the REQ-033 expiry, read 0x10 -> irq_n returns to 1; divisor stays /1; a reload of /64 restores /64 counting.
REQ-035 Write 0x08 DI=0x03, drive PI[7] 0->1 -> irq_n low 3 cycles later; read 0x11 -> DO=0x40, then irq_n=1; a 1->0 transition then sets nothing.
REQ-036 Assert rst mid-count with irq_n=0 -> all outputs at reset values asynchronously; no count after rst falls.
REQ-037 NPORTS=4, PORT_W=5: write/read all eight port/DDR registers -> upper DO bits read 0; reads of 0x09 and 0x12 give OE=0.
